uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Runtime-configurable UART receiver. It replaces the fixed-format receiver at the same position: after the baud divider, in front of the RX FIFO or bus register. It supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits, with 3-sample majority voting per bit. It reports parity, framing, break and overrun status through a valid/ready output holding register.

## Interface
- OVERSAMPLING, 16: DIVPULSE ticks per bit; even, >= 8.
- MAX_DATA_BITS, 9: width of RX_DO; must be >= 9 to support all CFG_DBITS values.
- CLK  in  1  system clock.
- NRST  in  1  reset, synchronous, active-low.
- DIVPULSE  in  1  one-CLK oversampling tick from the baud generator.
- RX_DSER  in  1  asynchronous serial line, idle high.
- CFG_DBITS  in  4  data bits per frame; legal 5..9; values <5 are treated as 5, values >9 as 9.
- CFG_PARITY  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
- CFG_STOP2  in  1  0: one stop bit, 1: two stop bits.
- RX_READY  in  1  consumer accepts the held word.
- RX_VALID  out  1  holding register contains a word.
- RX_DO  out  MAX_DATA_BITS  received data, LSB-first on the wire, right-aligned, unused upper bits 0.
- RX_PERR  out  1  parity error flag for the held word.
- RX_FERR  out  1  framing error flag for the held word (any stop bit sampled 0).
- RX_BREAK  out  1  break flag for the held word.
- RX_OVR  out  1  one-CLK pulse when a completed frame is dropped.

## Operation
- Input path:
  - RX_DSER passes through a 2-FF synchronizer (reset value 1).
  - All logic uses the synchronized value, `rxs`.
- Tick counter `tcnt` runs 0..OVERSAMPLING-1 and advances only on DIVPULSE. Let M = OVERSAMPLING/2.
  - Samples are taken at tcnt = M-1, M and M+1.
  - The bit value is the majority of the three samples and is decided at tcnt = M+1.
- States:
  - IDLE
    - On a DIVPULSE with `rxs`=0: go to START, tcnt <= 1.
    - Latch CFG_DBITS, CFG_PARITY and CFG_STOP2 into shadow registers. These are held for the whole frame; CFG changes mid-frame have no effect.
  - START
    - At the decision point, majority 1 (false start): go to IDLE, no output.
    - Otherwise continue. At tcnt = OVERSAMPLING-1, go to DATA.
  - DATA
    - Each decision stores into shift position idx (0..dbits-1).
    - After bit dbits-1 ends: go to PARITY if parity is enabled, else STOP.
  - PARITY
    - Decision computes perr: even mode requires an even count of ones in data+parity; odd mode requires an odd count.
    - At bit end: go to STOP.
  - STOP
    - Each stop-bit decision ORs (majority == 0) into ferr.
    - For the first of two stop bits, run to bit end and then check the second.
    - At the final stop bit's decision point, complete the frame and go to IDLE (or BRKWAIT). This gives half-bit early resync.
  - BRKWAIT
    - Entered when the frame completes with break.
    - Return to IDLE on the first DIVPULSE with `rxs`=1.
- Break condition: all data bits 0, parity bit 0 (if enabled) and first stop bit 0.
  - The frame is delivered with RX_BREAK=1, RX_FERR=1 and RX_DO=0.
  - RX_PERR is evaluated normally.
- Frame completion, loading the holding register:
  - If RX_VALID=0, or RX_VALID & RX_READY in the same cycle: load RX_DO and flags, RX_VALID=1.
  - Otherwise: drop the new frame, keep the held word, pulse RX_OVR.
- Handshake:
  - RX_VALID falls the cycle after RX_VALID & RX_READY, unless a new frame loads in that same cycle.
  - RX_DO and the flags are stable while RX_VALID=1.

## Timing
- Reset values:
  - RX_VALID, RX_PERR, RX_FERR, RX_BREAK and RX_OVR are 0.
  - RX_DO is 0.
  - State IDLE, tcnt 0, synchronizer 11.
- NRST low mid-frame: the frame is discarded, the held word is lost, and all outputs return to reset values on the next CLK edge.
- Pin-to-`rxs` latency: 2 CLK.
- Output latency: RX_VALID (or RX_OVR) is asserted on the CLK edge following the DIVPULSE cycle of the final stop-bit decision.
- Frame accounting: a frame occupies (1 + dbits + par + stops - 0.5) bit times before delivery.
- DIVPULSE semantics:
  - DIVPULSE is at most one cycle wide.
  - Nothing in the frame datapath advances without it.
  - Handshake logic runs every CLK.

## Test plan
- 8N1, OVERSAMPLING=16, send 0xA5 with RX_READY=1: RX_VALID pulses 1 cycle, RX_DO=0x0A5, all flags 0.
- 7E2, send 0x35 with the parity bit inverted: RX_DO=0x035, RX_PERR=1, RX_FERR=0. Repeat with the second stop bit 0: RX_FERR=1.
- 9O1, send 0x1FF with correct parity: RX_DO=0x1FF, RX_PERR=0. Change CFG_DBITS to 5 mid-frame: the result is unchanged.
- Low glitch of 5 ticks on an idle line: no RX_VALID; state returns to IDLE; the next valid frame 0x3C is received correctly.
- 8N1 line held low for 3 frame times, then high: exactly one word, RX_DO=0, RX_BREAK=1, RX_FERR=1; the next frame 0x55 is received normally.
- RX_READY=0, send 0x11 then 0x22: RX_DO stays 0x11, RX_OVR pulses once at the second frame's completion. Assert RX_READY with a frame completing in the same cycle: the new word loads and there is no RX_OVR.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits,
// 3-sample majority per bit, and a valid/ready holding register with parity/framing/break/overrun status.
module uart_rx_cfg #(
  parameter int OVERSAMPLING  = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     DIVPULSE,
  input  logic                     RX_DSER,
  input  logic [3:0]               CFG_DBITS,
  input  logic [1:0]               CFG_PARITY,
  input  logic                     CFG_STOP2,
  input  logic                     RX_READY,
  output logic                     RX_VALID,
  output logic [MAX_DATA_BITS-1:0] RX_DO,
  output logic                     RX_PERR,
  output logic                     RX_FERR,
  output logic                     RX_BREAK,
  output logic                     RX_OVR
);

  localparam int M  = OVERSAMPLING / 2;
  localparam int TW = $clog2(OVERSAMPLING);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  state_t                   r_state, w_state_nx;
  logic [TW-1:0]            r_tcnt, w_tcnt_nx, w_tcnt_inc;
  logic [1:0]               r_sync;
  logic                     r_s0, r_s1;
  logic [3:0]               r_dbits, r_idx, w_dbits_cfg;
  logic                     r_par_en, r_odd, r_stop2, r_stopn;
  logic [MAX_DATA_BITS-1:0] r_data;
  logic                     r_allz, r_perr, r_ferr, r_brk;
  logic                     r_valid, r_hperr, r_hferr, r_hbrk, r_ovr;
  logic [MAX_DATA_BITS-1:0] r_do;
  logic                     w_rxs, w_maj, w_dec, w_bend, w_last, w_final, w_done, w_brk_now;

  assign w_rxs      = r_sync[1];
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_dec      = (r_tcnt == TW'(M + 1));
  assign w_bend     = (r_tcnt == TW'(OVERSAMPLING - 1));
  assign w_tcnt_inc = w_bend ? '0 : r_tcnt + TW'(1);
  assign w_last     = (r_idx == r_dbits - 4'd1);
  assign w_final    = r_stopn | ~r_stop2;
  assign w_done     = DIVPULSE && (r_state == S_STOP) && w_dec && w_final;
  // Break is judged on the first stop bit; with two stop bits it was latched a bit earlier.
  assign w_brk_now  = r_stopn ? r_brk : (r_allz & ~w_maj);

  always_comb begin
    if (CFG_DBITS < 4'd5)      w_dbits_cfg = 4'd5;
    else if (CFG_DBITS > 4'd9) w_dbits_cfg = 4'd9;
    else                       w_dbits_cfg = CFG_DBITS;
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      r_sync  <= {r_sync[0], RX_DSER};
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tcnt_nx  = r_tcnt;
    if (DIVPULSE) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nx = S_START;
            w_tcnt_nx  = TW'(1);
          end else begin
            w_tcnt_nx  = '0;
          end
        end
        S_START: begin
          w_tcnt_nx = w_tcnt_inc;
          if (w_dec && w_maj) begin
            w_state_nx = S_IDLE;
            w_tcnt_nx  = '0;
          end else if (w_bend) begin
            w_state_nx = S_DATA;
          end else begin
            w_state_nx = S_START;
          end
        end
        S_DATA: begin
          w_tcnt_nx = w_tcnt_inc;
          if (w_bend && w_last) w_state_nx = r_par_en ? S_PAR : S_STOP;
          else                  w_state_nx = S_DATA;
        end
        S_PAR: begin
          w_tcnt_nx = w_tcnt_inc;
          if (w_bend) w_state_nx = S_STOP;
          else        w_state_nx = S_PAR;
        end
        S_STOP: begin
          w_tcnt_nx = w_tcnt_inc;
          if (w_done) begin
            w_state_nx = w_brk_now ? S_BRK : S_IDLE;
            w_tcnt_nx  = '0;
          end else begin
            w_state_nx = S_STOP;
          end
        end
        S_BRK: begin
          w_tcnt_nx  = '0;
          w_state_nx = w_rxs ? S_IDLE : S_BRK;
        end
        default: begin
          w_state_nx = S_IDLE;
          w_tcnt_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_s0 <= 1'b1; r_s1 <= 1'b1;
      r_dbits <= 4'd8; r_par_en <= 1'b0; r_odd <= 1'b0; r_stop2 <= 1'b0;
      r_idx <= 4'd0; r_data <= '0; r_allz <= 1'b0;
      r_perr <= 1'b0; r_ferr <= 1'b0; r_brk <= 1'b0; r_stopn <= 1'b0;
    end else if (DIVPULSE) begin
      if (r_tcnt == TW'(M - 1)) r_s0 <= w_rxs;
      if (r_tcnt == TW'(M))     r_s1 <= w_rxs;
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_dbits  <= w_dbits_cfg;
            r_par_en <= CFG_PARITY[0] ^ CFG_PARITY[1];
            r_odd    <= CFG_PARITY[1];
            r_stop2  <= CFG_STOP2;
            r_idx    <= 4'd0;
            r_data   <= '0;
            r_allz   <= 1'b1;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_brk    <= 1'b0;
            r_stopn  <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_dec) begin
            for (int i = 0; i < MAX_DATA_BITS; i++) begin
              if (r_idx == 4'(i)) r_data[i] <= w_maj;
            end
            r_allz <= r_allz & ~w_maj;
          end
          if (w_bend) r_idx <= r_idx + 4'd1;
        end
        S_PAR: begin
          if (w_dec) begin
            r_perr <= (^r_data) ^ w_maj ^ r_odd;
            r_allz <= r_allz & ~w_maj;
          end
        end
        S_STOP: begin
          if (w_dec) begin
            r_ferr <= r_ferr | ~w_maj;
            if (!r_stopn) r_brk <= r_allz & ~w_maj;
          end
          if (w_bend) r_stopn <= 1'b1;
        end
        default: r_idx <= r_idx;
      endcase
    end
  end

  // A completing frame loads whenever the slot is empty or being drained this cycle.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_valid <= 1'b0; r_do <= '0;
      r_hperr <= 1'b0; r_hferr <= 1'b0; r_hbrk <= 1'b0; r_ovr <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || RX_READY)) begin
        r_valid <= 1'b1;
        r_do    <= w_brk_now ? '0 : r_data;
        r_hperr <= r_perr;
        r_hferr <= r_ferr | ~w_maj;
        r_hbrk  <= w_brk_now;
      end else if (w_done) begin
        r_ovr   <= 1'b1;
      end else if (r_valid && RX_READY) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign RX_VALID = r_valid;
  assign RX_DO    = r_do;
  assign RX_PERR  = r_hperr;
  assign RX_FERR  = r_hferr;
  assign RX_BREAK = r_hbrk;
  assign RX_OVR   = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are built from their fields, expected words queued at send
// time, and a monitor pops and compares on every accepted output word.
module tb_uart_rx_cfg;

  logic       CLK = 1'b0;
  logic       NRST, DIVPULSE, RX_DSER, RX_READY, CFG_STOP2;
  logic [3:0] CFG_DBITS;
  logic [1:0] CFG_PARITY;
  logic       RX_VALID, RX_PERR, RX_FERR, RX_BREAK, RX_OVR;
  logic [8:0] RX_DO;

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
    logic       b;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, ovr_seen = 0, exp_ovr = 0, divcnt = 0;

  uart_rx_cfg #(.OVERSAMPLING(16), .MAX_DATA_BITS(9)) dut (
    .CLK(CLK), .NRST(NRST), .DIVPULSE(DIVPULSE), .RX_DSER(RX_DSER),
    .CFG_DBITS(CFG_DBITS), .CFG_PARITY(CFG_PARITY), .CFG_STOP2(CFG_STOP2),
    .RX_READY(RX_READY), .RX_VALID(RX_VALID), .RX_DO(RX_DO), .RX_PERR(RX_PERR),
    .RX_FERR(RX_FERR), .RX_BREAK(RX_BREAK), .RX_OVR(RX_OVR)
  );

  always #5 CLK = ~CLK;

  // Oversampling tick: one CLK wide, every 4th cycle.
  initial begin
    DIVPULSE = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      divcnt = divcnt + 1;
      DIVPULSE = (divcnt % 4 == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one pop per accepted word, plus overrun pulse counting.
  initial begin
    forever begin
      @(negedge CLK);
      if (NRST) begin
        if (RX_OVR) ovr_seen = ovr_seen + 1;
        if (RX_VALID && RX_READY) begin
          tests = tests + 1;
          if (expq.size() == 0) begin
            fails = fails + 1;
            $display("FAIL word_unexpected got d=%h p=%b f=%b b=%b required no word",
                     RX_DO, RX_PERR, RX_FERR, RX_BREAK);
          end else begin
            mon_e = expq.pop_front();
            if ({RX_DO, RX_PERR, RX_FERR, RX_BREAK} !== mon_e) begin
              fails = fails + 1;
              $display("FAIL word got d=%h p=%b f=%b b=%b required d=%h p=%b f=%b b=%b",
                       RX_DO, RX_PERR, RX_FERR, RX_BREAK, mon_e.d, mon_e.p, mon_e.f, mon_e.b);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    do @(posedge CLK); while (!DIVPULSE);
    #2;
  endtask

  task automatic idle(input int n);
    RX_DSER = 1'b1;
    repeat (n) tick();
  endtask

  // Builds the line levels from frame fields and derives the expected word from the framing rules.
  task automatic send_frame(input int data, input bit pflip, input logic [1:0] stops,
                            input bit push, input bit rdy_at_done, input bit midchg, input bit noise);
    bit   lvl[$];
    int   n, ns, d, ones, ft;
    bit   pen, odd, pbit, perr, ferr, brk;
    logic [3:0] orig;
    exp_t e;
    orig = CFG_DBITS;
    n    = (CFG_DBITS < 5) ? 5 : ((CFG_DBITS > 9) ? 9 : int'(CFG_DBITS));
    pen  = (CFG_PARITY == 2'b01) || (CFG_PARITY == 2'b10);
    odd  = (CFG_PARITY == 2'b10);
    ns   = CFG_STOP2 ? 2 : 1;
    d    = data & ((1 << n) - 1);
    ones = $countones(d);
    pbit = ((ones % 2) != 0) ^ odd ^ pflip;
    perr = pen && (((ones + int'(pbit)) % 2) != (odd ? 1 : 0));
    ferr = (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
    brk  = (d == 0) && (!pen || !pbit) && (stops[0] == 1'b0);
    e.d = brk ? 9'd0 : 9'(d);
    e.p = perr;
    e.f = ferr | brk;
    e.b = brk;
    if (push) expq.push_back(e);
    lvl.push_back(1'b0);
    for (int i = 0; i < n; i++) lvl.push_back(((d >> i) & 1) == 1);
    if (pen) lvl.push_back(pbit);
    lvl.push_back(stops[0]);
    if (ns == 2) lvl.push_back(stops[1]);
    for (int b = 0; b < lvl.size(); b++) begin
      ft = (noise && $urandom_range(0, 1) == 1) ? int'($urandom_range(7, 9)) : -1;
      for (int t = 0; t < 16; t++) begin
        if (midchg && b == 1 && t == 0) CFG_DBITS = 4'd5;
        RX_DSER = (t == ft) ? ~lvl[b] : lvl[b];
        if (rdy_at_done && b == lvl.size() - 1 && t == 9) begin
          while (!DIVPULSE) begin
            @(posedge CLK);
            #2;
          end
          RX_READY = 1'b1;
        end
        tick();
      end
    end
    RX_DSER = 1'b1;
    if (midchg) CFG_DBITS = orig;
  endtask

  initial begin
    logic [1:0] st;
    NRST = 1'b0; RX_DSER = 1'b1; RX_READY = 1'b1;
    CFG_DBITS = 4'd8; CFG_PARITY = 2'b00; CFG_STOP2 = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_valid", RX_VALID, 0);
    check("rst_do", RX_DO, 0);
    check("rst_perr", RX_PERR, 0);
    check("rst_ferr", RX_FERR, 0);
    check("rst_break", RX_BREAK, 0);
    check("rst_ovr", RX_OVR, 0);
    NRST = 1'b1;
    idle(20);

    send_frame(32'h0A5, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);

    CFG_DBITS = 4'd7; CFG_PARITY = 2'b01; CFG_STOP2 = 1'b1;
    send_frame(32'h035, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);
    send_frame(32'h035, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);

    CFG_DBITS = 4'd9; CFG_PARITY = 2'b10; CFG_STOP2 = 1'b0;
    send_frame(32'h1FF, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);
    send_frame(32'h1FF, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); idle(20);

    CFG_DBITS = 4'd8; CFG_PARITY = 2'b00; CFG_STOP2 = 1'b0;
    RX_DSER = 1'b0;
    repeat (5) tick();
    idle(30);
    check("glitch_no_valid", RX_VALID, 0);
    send_frame(32'h03C, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);

    expq.push_back({9'd0, 1'b0, 1'b1, 1'b1});
    RX_DSER = 1'b0;
    repeat (480) tick();
    idle(20);
    send_frame(32'h055, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);

    RX_READY = 1'b0;
    send_frame(32'h011, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0); idle(20);
    send_frame(32'h022, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); idle(20);
    exp_ovr = exp_ovr + 1;
    check("ovr_count", ovr_seen, exp_ovr);
    check("ovr_held_valid", RX_VALID, 1);
    check("ovr_held_do", RX_DO, 32'h011);
    send_frame(32'h033, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0); idle(20);
    check("ready_same_cycle_no_ovr", ovr_seen, exp_ovr);

    RX_READY = 1'b0;
    send_frame(32'h044, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); idle(20);
    check("held_before_reset", RX_VALID, 1);
    RX_DSER = 1'b0;
    repeat (40) tick();
    NRST = 1'b0;
    @(posedge CLK);
    #2;
    check("midreset_valid", RX_VALID, 0);
    check("midreset_do", RX_DO, 0);
    NRST = 1'b1;
    RX_READY = 1'b1;
    idle(40);
    check("after_reset_valid", RX_VALID, 0);

    for (int k = 0; k < 25; k++) begin
      CFG_DBITS  = 4'($urandom_range(3, 11));
      CFG_PARITY = 2'($urandom_range(0, 3));
      CFG_STOP2  = 1'($urandom_range(0, 1));
      st[0] = ($urandom_range(0, 7) != 0);
      st[1] = ($urandom_range(0, 7) != 0);
      send_frame(int'($urandom_range(0, 511)), ($urandom_range(0, 3) == 0), st,
                 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20 + int'($urandom_range(0, 20)));
    end

    idle(40);
    check("queue_drained", expq.size(), 0);
    check("ovr_final", ovr_seen, exp_ovr);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
